// File: rtl/acc_seq_ctrl_if.sv
// Memory request/acknowledge port between the sequencer and program/data memory.
interface acc_seq_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   // Sequencer side issues requests
   modport master (
      output mem_req, mem_we, mem_addr,
      input  mem_ack, mem_rdata
   );

   // Memory side answers them
   modport slave (
      input  mem_req, mem_we, mem_addr,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/acc_seq_ctrl.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator datapath.
// Owns PC, IR and MDR; all outputs are registered so nothing depends
// combinationally on mem_ack.
module acc_seq_ctrl #(
   parameter int                DATA_W   = 8,
   parameter int                ADDR_W   = 5,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              acc_zero,
   acc_seq_ctrl_if.master    bus,
   output logic [DATA_W-1:0] mdr,
   output logic              acc_we,
   output logic              acc_src,
   output logic [1:0]        alu_op,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              halted
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_LDA = 3'b001;
   localparam logic [2:0] OP_STA = 3'b010;
   localparam logic [2:0] OP_ADD = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_JMP = 3'b101;
   localparam logic [2:0] OP_JZ  = 3'b110;
   localparam logic [2:0] OP_HLT = 3'b111;

   localparam logic [1:0] ALU_PASS = 2'b00;
   localparam logic [1:0] ALU_ADD  = 2'b01;
   localparam logic [1:0] ALU_SUB  = 2'b10;

   state_t            state;
   logic [DATA_W-1:0] ir;
   logic              req_r;
   logic              we_r;
   logic [ADDR_W-1:0] addr_r;

   logic [2:0]        opcode;
   logic [ADDR_W-1:0] operand;
   logic [ADDR_W-1:0] nxt_pc;
   logic [1:0]        wb_op;
   logic              mem_done;

   assign opcode   = ir[DATA_W-1 -: 3];
   assign operand  = ir[ADDR_W-1:0];
   // Only an ack against our own outstanding request completes it
   assign mem_done = req_r & bus.mem_ack;

   assign bus.mem_req  = req_r;
   assign bus.mem_we   = we_r;
   assign bus.mem_addr = addr_r;

   // Branch resolution in DECODE: JMP always, JZ only when ACC is zero
   always_comb begin
      nxt_pc = pc;
      if (opcode == OP_JMP || (opcode == OP_JZ && acc_zero))
         nxt_pc = operand;
   end

   // ALU op presented during write-back
   always_comb begin
      wb_op = ALU_PASS;
      if (opcode == OP_ADD)
         wb_op = ALU_ADD;
      else if (opcode == OP_SUB)
         wb_op = ALU_SUB;
   end

   // Sequencer state machine; outputs are set on the edge entering each state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         pc      <= RESET_PC;
         ir      <= '0;
         mdr     <= '0;
         req_r   <= 1'b0;
         we_r    <= 1'b0;
         addr_r  <= '0;
         acc_we  <= 1'b0;
         acc_src <= 1'b0;
         alu_op  <= ALU_PASS;
         busy    <= 1'b0;
         halted  <= 1'b0;
      end else begin
         acc_we <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state  <= S_FETCH;
                  req_r  <= 1'b1;
                  we_r   <= 1'b0;
                  addr_r <= pc;
                  busy   <= 1'b1;
               end
            end
            S_FETCH: begin
               if (mem_done) begin
                  ir    <= bus.mem_rdata;
                  pc    <= pc + ADDR_W'(1);
                  req_r <= 1'b0;
                  state <= S_DECODE;
               end
            end
            S_DECODE: begin
               case (opcode)
                  OP_HLT: begin
                     state  <= S_HALT;
                     busy   <= 1'b0;
                     halted <= 1'b1;
                  end
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                     state  <= S_MEM;
                     req_r  <= 1'b1;
                     we_r   <= (opcode == OP_STA);
                     addr_r <= operand;
                  end
                  default: begin
                     // NOP, JMP, JZ: straight back to fetch at the resolved PC
                     pc     <= nxt_pc;
                     state  <= S_FETCH;
                     req_r  <= 1'b1;
                     we_r   <= 1'b0;
                     addr_r <= nxt_pc;
                  end
               endcase
            end
            S_MEM: begin
               if (mem_done) begin
                  if (we_r) begin
                     // Store done; request stays up for the next fetch
                     state  <= S_FETCH;
                     we_r   <= 1'b0;
                     addr_r <= pc;
                  end else begin
                     mdr     <= bus.mem_rdata;
                     req_r   <= 1'b0;
                     state   <= S_WB;
                     acc_we  <= 1'b1;
                     acc_src <= (opcode == OP_LDA);
                     alu_op  <= wb_op;
                  end
               end
            end
            S_WB: begin
               state   <= S_FETCH;
               req_r   <= 1'b1;
               we_r    <= 1'b0;
               addr_r  <= pc;
               acc_src <= 1'b0;
               alu_op  <= ALU_PASS;
            end
            S_HALT: begin
               // Only reset leaves HALT
            end
            default: begin
               state <= S_IDLE;
               req_r <= 1'b0;
               we_r  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Bench for acc_seq_ctrl: memory responder with programmable ack delay,
// negedge accumulator datapath, and an instruction-level reference model.
module tb_acc_seq_ctrl;
   localparam int DW = 8;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          acc_zero;
   logic [DW-1:0] mdr;
   logic          acc_we;
   logic          acc_src;
   logic [1:0]    alu_op;
   logic [AW-1:0] pc;
   logic          busy;
   logic          halted;

   acc_seq_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   acc_seq_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC('0)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .acc_zero (acc_zero),
      .bus      (bus),
      .mdr      (mdr),
      .acc_we   (acc_we),
      .acc_src  (acc_src),
      .alu_op   (alu_op),
      .pc       (pc),
      .busy     (busy),
      .halted   (halted)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [7:0]  img     [32];
   logic [7:0]  mem_arr [32];
   logic [7:0]  acc;
   int          dly[$];
   int          di;
   bit          spur;
   bit          rst_hit;
   int          viol;
   logic [13:0] got_q[$];
   logic [13:0] exp_q[$];
   int          exp_pc, exp_acc, exp_mdr, exp_cyc;
   bit          exp_halt;
   int          run_cyc;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int dget(int k);
      return (k < dly.size()) ? dly[k] : 0;
   endfunction

   // Memory + accumulator datapath, acting on the falling edge
   initial begin
      bit pend = 0;
      int cnt = 0;
      bit last_req = 0, last_ack = 0, last_accwe = 0;
      acc = '0;
      acc_zero = 1'b1;
      bus.mem_ack = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst) acc = '0;
         else if (acc_we) begin
            if (acc_src) acc = mdr;
            else case (alu_op)
               2'b01:   acc = acc + mdr;
               2'b10:   acc = acc - mdr;
               default: acc = mdr;
            endcase
         end
         acc_zero = (acc == 8'd0);
         if (!rst && !rst_hit && last_req && !last_ack && !bus.mem_req) viol++;
         if (acc_we && last_accwe) viol++;
         if (rst_hit) begin pend = 0; rst_hit = 0; end
         if (!bus.mem_req) begin
            pend = 0;
            bus.mem_ack = spur && ($urandom_range(0, 1) == 1);
            bus.mem_rdata = 8'($urandom);
         end else begin
            if (!pend) begin pend = 1; cnt = dget(di); di++; end
            if (cnt == 0) begin
               bus.mem_ack = 1'b1;
               pend = 0;
               if (bus.mem_we) begin
                  mem_arr[bus.mem_addr] = acc;
                  got_q.push_back({1'b1, bus.mem_addr, acc});
                  bus.mem_rdata = 8'($urandom);
               end else begin
                  bus.mem_rdata = mem_arr[bus.mem_addr];
                  got_q.push_back({1'b0, bus.mem_addr, 8'h00});
               end
            end else begin
               bus.mem_ack = 1'b0;
               cnt--;
               bus.mem_rdata = 8'($urandom);
            end
         end
         last_req = bus.mem_req;
         last_ack = bus.mem_ack;
         last_accwe = acc_we;
      end
   end

   // Instruction-level model: request list, final state, and cycle cost
   // (cycles counted from the edge that samples start to the edge entering HALT)
   task automatic ref_run(input int max_req);
      logic [7:0] m[32];
      int p, a_m, d_m, k, cyc, nreq, ins, op, a;
      for (int i = 0; i < 32; i++) m[i] = img[i];
      p = 0; a_m = 0; d_m = 0; k = 0; cyc = 1; nreq = 0;
      exp_halt = 0;
      exp_q.delete();
      while (!exp_halt && nreq < max_req) begin
         ins = int'(m[p]);
         exp_q.push_back({1'b0, 5'(p), 8'h00});
         cyc += dget(k) + 1; k++; nreq++;
         p = (p + 1) % 32;
         if (nreq >= max_req) break;
         op = ins / 32;
         a = ins % 32;
         cyc += 1;
         case (op)
            7: exp_halt = 1;
            5: p = a;
            6: if (a_m == 0) p = a;
            1, 3, 4: begin
               exp_q.push_back({1'b0, 5'(a), 8'h00});
               cyc += dget(k) + 1; k++; nreq++;
               d_m = int'(m[a]);
               if (op == 1) a_m = d_m;
               else if (op == 3) a_m = (a_m + d_m) % 256;
               else a_m = (a_m - d_m + 256) % 256;
               cyc += 1;
            end
            2: begin
               exp_q.push_back({1'b1, 5'(a), 8'(a_m)});
               m[a] = 8'(a_m);
               cyc += dget(k) + 1; k++; nreq++;
            end
            default: ;
         endcase
      end
      exp_pc = p; exp_acc = a_m; exp_mdr = d_m; exp_cyc = cyc;
   endtask

   task automatic prep(input int dmode, input int max_req);
      dly.delete();
      for (int i = 0; i < 2 * max_req + 4; i++)
         dly.push_back(dmode < 0 ? int'($urandom_range(0, 3)) : dmode);
      ref_run(max_req);
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst = 1'b1; rst_hit = 1'b1;
      repeat (2) @(negedge clk);
      @(posedge clk); #2;
      rst = 1'b0;
   endtask

   task automatic exec(input string tag, input int max_req, input bit rnd);
      bit done = 0;
      int n;
      do_reset();
      for (int i = 0; i < 32; i++) mem_arr[i] = img[i];
      got_q.delete(); di = 0; viol = 0; spur = rnd;
      @(negedge clk); start = 1'b1;
      run_cyc = 0;
      while (!done) begin
         @(posedge clk); run_cyc++; #1;
         start = 1'b0;
         if (halted || got_q.size() >= max_req || run_cyc > exp_cyc + 50) done = 1;
         else if (rnd && $urandom_range(0, 7) == 0) start = 1'b1;
      end
      start = 1'b0;
      chk({tag, "_halt"}, 32'(halted), 32'(exp_halt));
      chk({tag, "_nreq"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         if (got_q[i] !== exp_q[i]) begin
            chk({tag, "_req"}, 32'(got_q[i]), 32'(exp_q[i]));
            break;
         end
      end
      chk({tag, "_viol"}, viol, 0);
      if (exp_halt) begin
         chk({tag, "_cyc"}, run_cyc, exp_cyc);
         chk({tag, "_pc"}, 32'(pc), exp_pc);
         chk({tag, "_acc"}, 32'(acc), exp_acc);
         chk({tag, "_mdr"}, 32'(mdr), exp_mdr);
         chk({tag, "_busy"}, 32'(busy), 0);
         @(negedge clk); start = 1'b1;
         @(negedge clk); start = 1'b0;
         repeat (2) @(negedge clk);
         chk({tag, "_stayhalt"}, {halted, bus.mem_req, 3'b0, pc}, {1'b1, 1'b0, 3'b0, 5'(exp_pc)});
      end
      spur = 0;
   endtask

   function automatic logic [13:0] got_at(int i);
      return (i < got_q.size()) ? got_q[i] : 14'h3fff;
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; spur = 0; rst_hit = 1; viol = 0; di = 0;
      for (int i = 0; i < 32; i++) begin img[i] = '0; mem_arr[i] = '0; end
      repeat (2) @(negedge clk);
      @(posedge clk); #2; rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", {bus.mem_req, bus.mem_we, acc_we, acc_src, alu_op}, 0);
      chk("rst_stat", {busy, halted}, 0);
      chk("rst_pc", 32'(pc), 0);
      chk("rst_mdr", 32'(mdr), 0);

      // Reference program with single-cycle and three-wait-state memory
      img[0] = 8'h2A; img[1] = 8'h6B; img[2] = 8'h4C; img[3] = 8'hE0;
      img[10] = 8'd5; img[11] = 8'd7;
      prep(0, 120);
      exec("ex0", 120, 0);
      chk("ex0_wr", 32'(got_at(5)), 32'({1'b1, 5'd12, 8'd12}));
      chk("ex0_pcv", 32'(pc), 4);
      chk("ex0_cycv", run_cyc, 14);
      prep(3, 120);
      exec("ex3", 120, 0);
      chk("ex3_wr", 32'(got_at(5)), 32'({1'b1, 5'd12, 8'd12}));
      chk("ex3_cycv", run_cyc, 35);

      // JZ taken with ACC=0
      for (int i = 0; i < 32; i++) img[i] = '0;
      img[0] = 8'hD4; img[20] = 8'hE0;
      prep(0, 120);
      exec("jzt", 120, 0);
      chk("jzt_tgt", 32'(got_at(1)), 32'({1'b0, 5'd20, 8'd0}));

      // JZ not taken with ACC=9
      for (int i = 0; i < 32; i++) img[i] = '0;
      img[0] = 8'h3E; img[1] = 8'hD4; img[2] = 8'hE0; img[20] = 8'hE0; img[30] = 8'd9;
      prep(1, 120);
      exec("jzn", 120, 0);
      chk("jzn_tgt", 32'(got_at(3)), 32'({1'b0, 5'd2, 8'd0}));

      // JMP 31 sitting at 31 keeps fetching 31
      for (int i = 0; i < 32; i++) img[i] = '0;
      img[0] = 8'hBF; img[31] = 8'hBF;
      prep(0, 5);
      exec("jmp31", 5, 0);
      chk("jmp31_f", 32'(got_at(3)), 32'({1'b0, 5'd31, 8'd0}));

      // NOP at 31 wraps the next fetch to 0
      img[31] = 8'h00;
      prep(0, 6);
      exec("wrap", 6, 0);
      chk("wrap_f", 32'(got_at(2)), 32'({1'b0, 5'd0, 8'd0}));

      // Reset while an operand read is waiting for ack
      for (int i = 0; i < 32; i++) img[i] = '0;
      img[0] = 8'h2A; img[10] = 8'd5;
      prep(6, 10);
      do_reset();
      for (int i = 0; i < 32; i++) mem_arr[i] = img[i];
      got_q.delete(); di = 0; spur = 0;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      for (int i = 0; i < 40 && !(bus.mem_req && bus.mem_addr == 5'd10); i++) begin
         @(posedge clk); #1;
      end
      chk("rm_inmem", 32'(bus.mem_req && bus.mem_addr == 5'd10 && !bus.mem_we), 1);
      #1; rst = 1'b1; rst_hit = 1'b1;
      #1;
      chk("rm_req", 32'(bus.mem_req), 0);
      chk("rm_stat", {busy, halted, pc}, 0);
      @(posedge clk); #2; rst = 1'b0; spur = 1;
      repeat (6) @(posedge clk);
      #1;
      chk("rm_idle", {busy, bus.mem_req, acc_we, pc}, 0);
      spur = 0;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      chk("rm_restart", {bus.mem_req, bus.mem_we, bus.mem_addr}, {1'b1, 1'b0, 5'd0});

      // Random programs, random wait states, stray acks and start pulses
      for (int t = 0; t < 25; t++) begin
         for (int tries = 0; tries < 50; tries++) begin
            for (int i = 0; i < 32; i++) img[i] = 8'($urandom);
            prep(-1, 120);
            if (exp_halt) break;
         end
         exec($sformatf("rnd%0d", t), 120, 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
